// File: rtl/uart_rx_ctrl.sv
// Frame sequencer for the UART receiver: start detection, per-bit edge/bit counting,
// check/sample strobes and the end-of-frame DATA_VALID / FRAME_ERR pulse.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESC_W    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    input  logic               par_en,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               strt_err,
    input  logic               par_err,
    input  logic               stp_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic               dat_samp_en,
    output logic               strt_chk_en,
    output logic               deser_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               frame_err
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e             state_q;
    logic [PRESC_W-1:0] edge_cnt_q;
    logic [BitW-1:0]    bit_cnt_q;
    logic [PRESC_W-1:0] p_q;
    logic               par_en_q;
    logic               par_err_q;
    logic               data_valid_q;
    logic               frame_err_q;

    logic [PRESC_W-1:0] p_sel;
    logic [PRESC_W-1:0] ck;
    logic [PRESC_W-1:0] ck_next;
    logic [PRESC_W-1:0] p_last;
    logic               at_ck;
    logic               at_ck_next;
    logic               wrap;

    // Unsupported oversampling ratios fall back to 8.
    always_comb begin
        p_sel = PRESC_W'(8);
        if (prescale == PRESC_W'(16) || prescale == PRESC_W'(32)) begin
            p_sel = prescale;
        end
    end

    // The sampler votes on edges P/2-1..P/2+1, so its result is settled at P/2+2.
    assign ck         = (p_q >> 1) + PRESC_W'(2);
    assign ck_next    = ck + PRESC_W'(1);
    assign p_last     = p_q - PRESC_W'(1);
    assign at_ck      = (edge_cnt_q == ck);
    assign at_ck_next = (edge_cnt_q == ck_next);
    assign wrap       = (edge_cnt_q == p_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            p_q          <= PRESC_W'(8);
            par_en_q     <= 1'b0;
            par_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q != StIdle) begin
                edge_cnt_q <= wrap ? '0 : edge_cnt_q + PRESC_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (!rx_in) begin
                        state_q    <= StStart;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        p_q        <= p_sel;
                        par_en_q   <= par_en;
                    end
                end
                StStart: begin
                    if (at_ck_next && strt_err) begin
                        state_q    <= StIdle;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end else if (wrap) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (wrap) begin
                        if (bit_cnt_q == BitW'(DATA_WIDTH - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                        end
                    end
                end
                StParity: begin
                    if (at_ck_next) begin
                        par_err_q <= par_err;
                    end
                    if (wrap) begin
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    // Leave before the stop bit ends so a back-to-back start edge is seen.
                    if (at_ck_next) begin
                        state_q    <= StIdle;
                        edge_cnt_q <= '0;
                        par_err_q  <= 1'b0;
                        if (stp_err || par_err_q) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                end
            endcase
        end
    end

    assign edge_cnt    = edge_cnt_q;
    assign dat_samp_en = (state_q != StIdle);
    assign strt_chk_en = (state_q == StStart)  && at_ck;
    assign deser_en    = (state_q == StData)   && at_ck;
    assign par_chk_en  = (state_q == StParity) && at_ck;
    assign stp_chk_en  = (state_q == StStop)   && at_ck;
    assign data_valid  = data_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Table-driven bench for uart_rx_ctrl: per-frame strobe/pulse counts and detect-to-pulse
// latency, plus hand sequences for reset, back-to-back frames and mid-frame input changes.
module tb_uart_rx_ctrl;

    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_in = 1'b1;
    logic          par_en = 1'b0;
    logic [PW-1:0] prescale = 6'd8;
    logic          strt_err = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic          dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
    logic          data_valid, frame_err;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .prescale   (prescale),
        .strt_err   (strt_err),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .edge_cnt   (edge_cnt),
        .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en),
        .deser_en   (deser_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Monitor counters, indexed by the constants below; written only by the monitor.
    localparam int MDes = 0, MVal = 1, MFer = 2, MPar = 3, MStp = 4, MStr = 5, MBad = 6,
                   MMul = 7;
    int cyc = 0;
    int t_detect = 0;
    int last_lat = -1;
    int exp_ck = 6;
    int mon [0:7];
    int snap [0:7];

    initial for (int i = 0; i < 8; i++) mon[i] = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (deser_en) begin
            mon[MDes] <= mon[MDes] + 1;
            if (int'(edge_cnt) != exp_ck) mon[MBad] <= mon[MBad] + 1;
        end
        if (data_valid)  mon[MVal] <= mon[MVal] + 1;
        if (frame_err)   mon[MFer] <= mon[MFer] + 1;
        if (par_chk_en)  mon[MPar] <= mon[MPar] + 1;
        if (stp_chk_en)  mon[MStp] <= mon[MStp] + 1;
        if (strt_chk_en) mon[MStr] <= mon[MStr] + 1;
        if ($countones({strt_chk_en, deser_en, par_chk_en, stp_chk_en}) > 1)
            mon[MMul] <= mon[MMul] + 1;
        if (data_valid || frame_err) last_lat <= cyc - t_detect;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic take_snap();
        for (int i = 0; i < 8; i++) snap[i] = mon[i];
        last_lat = -1;
    endtask

    function automatic int delta(input int idx);
        return mon[idx] - snap[idx];
    endfunction

    // Drives a serial frame starting at a falling edge; rx_in low is sampled on the next posedge.
    task automatic drive_frame(input logic [7:0] data, input int p, input bit par,
                               input int stop_len);
        rx_in = 1'b0;
        t_detect = cyc + 1;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            repeat (p) @(negedge clk);
        end
        if (par) begin
            rx_in = ^data;
            repeat (p) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (stop_len) @(negedge clk);
    endtask

    typedef struct {
        string      name;
        bit         glitch;
        int         p_in;
        int         p_exp;
        bit         par;
        bit         s_err;
        bit         p_err;
        bit         t_err;
        logic [7:0] data;
        int         e_des;
        int         e_val;
        int         e_fer;
        int         e_par;
        int         e_stp;
        int         e_lat;
    } vec_t;

    vec_t vecs [0:7];

    initial begin
        //          name         gl  pin pex par se pe te data   des val fer par stp lat
        vecs[0] = '{"p8_55",     0,  8,  8,  0,  0, 0, 0, 8'h55, 8,  1,  0,  0,  1,  80};
        vecs[1] = '{"glitch",    1,  8,  8,  0,  1, 0, 0, 8'h00, 0,  0,  0,  0,  0,  -1};
        vecs[2] = '{"p16_parerr",0,  16, 16, 1,  0, 1, 0, 8'hA3, 8,  0,  1,  1,  1,  172};
        vecs[3] = '{"p8_stperr", 0,  8,  8,  0,  0, 0, 1, 8'h3C, 8,  0,  1,  0,  1,  80};
        vecs[4] = '{"p8_clean",  0,  8,  8,  0,  0, 0, 0, 8'hC3, 8,  1,  0,  0,  1,  80};
        vecs[5] = '{"p32_clean", 0,  32, 32, 0,  0, 0, 0, 8'h81, 8,  1,  0,  0,  1,  308};
        vecs[6] = '{"p20_as8",   0,  20, 8,  0,  0, 0, 0, 8'h5A, 8,  1,  0,  0,  1,  80};
        vecs[7] = '{"p16_par",   0,  16, 16, 1,  0, 0, 0, 8'h96, 8,  1,  0,  1,  1,  172};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_edge_cnt", int'(edge_cnt), 0);
        check("rst_samp_en", int'(dat_samp_en), 0);
        check("rst_strobes", int'({strt_chk_en, deser_en, par_chk_en, stp_chk_en}), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            prescale = PW'(vecs[v].p_in);
            par_en   = vecs[v].par;
            strt_err = vecs[v].s_err;
            par_err  = vecs[v].p_err;
            stp_err  = vecs[v].t_err;
            exp_ck   = vecs[v].p_exp / 2 + 2;
            take_snap();
            if (vecs[v].glitch) begin
                rx_in = 1'b0;
                repeat (2) @(negedge clk);
                rx_in = 1'b1;
                repeat (2 * vecs[v].p_exp) @(negedge clk);
                check({vecs[v].name, "_strt_chk"}, delta(MStr), 1);
            end else begin
                drive_frame(vecs[v].data, vecs[v].p_exp, vecs[v].par, vecs[v].p_exp);
            end
            repeat (4) @(negedge clk);
            check({vecs[v].name, "_deser"}, delta(MDes), vecs[v].e_des);
            check({vecs[v].name, "_valid"}, delta(MVal), vecs[v].e_val);
            check({vecs[v].name, "_ferr"}, delta(MFer), vecs[v].e_fer);
            check({vecs[v].name, "_par_chk"}, delta(MPar), vecs[v].e_par);
            check({vecs[v].name, "_stp_chk"}, delta(MStp), vecs[v].e_stp);
            check({vecs[v].name, "_deser_edge"}, delta(MBad), 0);
            check({vecs[v].name, "_onehot"}, delta(MMul), 0);
            check({vecs[v].name, "_idle"}, int'(dat_samp_en), 0);
            if (vecs[v].e_lat >= 0) check({vecs[v].name, "_latency"}, last_lat, vecs[v].e_lat);
        end
        strt_err = 1'b0;
        par_err  = 1'b0;
        stp_err  = 1'b0;

        // Back-to-back frames at P=32: second start lands in the IDLE cycle after the stop exit
        prescale = 6'd32;
        par_en   = 1'b0;
        exp_ck   = 18;
        take_snap();
        drive_frame(8'h0F, 32, 1'b0, 18 + 3);
        drive_frame(8'hF0, 32, 1'b0, 32);
        repeat (4) @(negedge clk);
        check("b2b_valid", delta(MVal), 2);
        check("b2b_deser", delta(MDes), 16);
        check("b2b_ferr", delta(MFer), 0);
        check("b2b_deser_edge", delta(MBad), 0);
        check("b2b_latency2", last_lat, 308);

        // Reset in the middle of the data bits
        prescale = 6'd8;
        exp_ck   = 6;
        take_snap();
        rx_in = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_in_frame", int'(dat_samp_en), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_edge_cnt", int'(edge_cnt), 0);
        check("mid_rst_samp_en", int'(dat_samp_en), 0);
        check("mid_rst_strobes", int'({strt_chk_en, deser_en, par_chk_en, stp_chk_en}), 0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_rst_no_valid", delta(MVal), 0);
        check("mid_rst_no_ferr", delta(MFer), 0);
        check("mid_rst_idle", int'(dat_samp_en), 0);
        take_snap();
        drive_frame(8'h5A, 8, 1'b0, 8);
        repeat (4) @(negedge clk);
        check("after_rst_valid", delta(MVal), 1);
        check("after_rst_latency", last_lat, 80);

        // PRESCALE and PAR_EN changed mid-frame must not affect the frame in flight
        prescale = 6'd8;
        par_en   = 1'b0;
        exp_ck   = 6;
        take_snap();
        fork
            drive_frame(8'h33, 8, 1'b0, 8);
            begin
                repeat (10) @(negedge clk);
                prescale = 6'd16;
                par_en   = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("chg_valid", delta(MVal), 1);
        check("chg_deser", delta(MDes), 8);
        check("chg_par_chk", delta(MPar), 0);
        check("chg_deser_edge", delta(MBad), 0);
        check("chg_latency", last_lat, 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
